// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: single-clock SPI master framing {cmd,wdata} onto MOSI and capturing read data from MISO; SPI_MASTER_ABORT_EN adds abort/aborted
module spi_master_ctrl #(
   parameter int TURNAROUND = 2,
   parameter int GAP_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] wdata,
`ifdef SPI_MASTER_ABORT_EN
   input  logic       abort,
   output logic       aborted,
`endif
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   typedef enum logic [2:0] {IDLE, SEL, CHK, SHIFT, TURN, RECV, DONE, GAP} state_t;
   localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [9:0] frame;
   logic [6:0] sreg;
   logic accept, gap_end, abort_hit;
`ifdef SPI_MASTER_ABORT_EN
   assign abort_hit = abort && state inside {SEL, CHK, SHIFT, TURN, RECV};
`else
   assign abort_hit = 1'b0;
`endif
   // next state, saturating phase counter and outputs decoded from the current state;
   // the last gap cycle already counts as idle so a held start chains frames with exactly GAP_CYCLES high cycles
   always_comb begin
      gap_end = (state == DONE && GAP_CYCLES == 1) || (state == GAP && cnt == GAP_LAST);
      busy = !(state == IDLE || gap_end);
      accept = start && !busy;
      state_nxt = state;
      case (state)
         SEL:     state_nxt = CHK;
         CHK:     state_nxt = SHIFT;
         SHIFT:   if (cnt == 4'd9) state_nxt = frame[9:8] != 2'b11 ? DONE : TURNAROUND == 0 ? RECV : TURN;
         TURN:    if (cnt == TURN_LAST) state_nxt = RECV;
         RECV:    if (cnt == 4'd7) state_nxt = DONE;
         DONE:    state_nxt = GAP_CYCLES == 1 ? IDLE : GAP;
         GAP:     if (cnt == GAP_LAST) state_nxt = IDLE;
         default: state_nxt = state;
      endcase
      if (abort_hit) state_nxt = GAP;
      if (accept) state_nxt = SEL;
      cnt_nxt = state_nxt != state ? {3'b000, state == DONE} : cnt == 4'hF ? cnt : cnt + 4'd1;
      SS_n = state inside {IDLE, DONE, GAP};
      MOSI = state == CHK ? frame[9] : state == SHIFT ? frame[4'd9 - cnt] : 1'b0;
      done = state == DONE;
      rd_valid = state == DONE && frame[9:8] == 2'b11;
   end
   // state, counter, latched request and received word
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         frame <= '0;
         sreg <= '0;
         rd_data <= '0;
      end else begin
         state <= state_nxt;
         cnt <= cnt_nxt;
         if (accept) frame <= {cmd, wdata};
         if (state == RECV) sreg <= {sreg[5:0], MISO};
         if (state == RECV && state_nxt == DONE) rd_data <= {sreg, MISO};
      end
   end
`ifdef SPI_MASTER_ABORT_EN
   // one-cycle pulse in the first cycle after an abort forces SS_n high
   always_ff @(posedge clk) begin
      if (!rst_n) aborted <= 1'b0;
      else aborted <= abort_hit;
   end
`endif
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized scoreboard bench for spi_master_ctrl
module tb_spi_master_ctrl;
   localparam int T = 2;
   localparam int G = 1;
   typedef struct {
      logic [1:0] cmd;
      logic [7:0] wdata;
      logic [7:0] miso;
      bit         b2b;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, MISO = 1'b0;
   logic [1:0] cmd = 2'b00;
   logic [7:0] wdata = 8'hFF;
   logic busy, done, rd_valid, SS_n, MOSI;
   logic [7:0] rd_data;
`ifdef SPI_MASTER_ABORT_EN
   logic abort = 1'b0;
   logic aborted;
`endif
   exp_t exp_q[$];
   logic [7:0] miso_q[$];
   int n_cmp = 0, n_bad = 0;

   spi_master_ctrl #(.TURNAROUND(T), .GAP_CYCLES(G)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .wdata(wdata),
`ifdef SPI_MASTER_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // waits for the master to be free, then issues one request
   task automatic send(input logic [1:0] c, input logic [7:0] d, input logic [7:0] m, input bit push);
      int w = 0;
      @(negedge clk);
      while (busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("idle_wait", busy, 0);
      cmd = c;
      wdata = d;
      start = 1'b1;
      if (push) exp_q.push_back('{c, d, m, 1'b0});
      miso_q.push_back(m);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // slave model: presents the queued word MSB-first during the receive window, noise elsewhere
   int k = 0;
   logic [7:0] cur = 8'h00;
   logic ssn_d = 1'b1;
   always @(negedge clk) begin
      if (!SS_n && ssn_d) begin
         k = 0;
         cur = 8'h00;
         if (miso_q.size() > 0) cur = miso_q.pop_front();
      end else if (!SS_n) k++;
      MISO = (!SS_n && k >= 12 + T && k < 20 + T) ? cur[19 + T - k] : 1'($urandom);
      ssn_d = SS_n;
   end

   // monitor: collects MOSI while selected and scores every completed frame
   int cyc = 0, rise_cyc = 0;
   bit have_rise = 1'b0;
   logic ssn_q = 1'b1;
   logic bits[$];
   logic [7:0] model_rd = 8'h00;
   always @(negedge clk) begin
      exp_t e;
      logic [11:0] act_mosi, exp_mosi;
      logic turn_or;
      bit rd;
      cyc++;
      if (!rst_n) begin
         bits.delete();
         model_rd = 8'h00;
         ssn_q = 1'b1;
      end else begin
         if (ssn_q && !SS_n && have_rise && exp_q.size() > 0) begin
            if (exp_q[0].b2b) chk("gap_exact", cyc - rise_cyc, G);
            else chk("gap_min", (cyc - rise_cyc) >= G, 1);
         end
         if (!SS_n) bits.push_back(MOSI);
         if (rd_valid && !done) chk("rd_valid_alone", rd_valid, 0);
         if (done) begin
            chk("done_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               rd = e.cmd == 2'b11;
               exp_mosi = {1'b0, e.cmd[1], e.cmd, e.wdata};
               act_mosi = '0;
               for (int i = 0; i < 12; i++) act_mosi = {act_mosi[10:0], i < bits.size() ? bits[i] : 1'bx};
               turn_or = 1'b0;
               for (int i = 0; i < T; i++) if (12 + i < bits.size()) turn_or = turn_or | bits[12 + i];
               if (rd) model_rd = e.miso;
               chk("ss_low_len", bits.size(), rd ? 20 + T : 12);
               chk("mosi_bits", act_mosi, exp_mosi);
               if (rd) chk("turn_mosi", turn_or, 0);
               chk("rd_valid", rd_valid, rd);
               chk("rd_data", rd_data, model_rd);
               chk("ss_n_at_done", SS_n, 1);
            end
            bits.delete();
            rise_cyc = cyc;
            have_rise = 1'b1;
         end
         ssn_q = SS_n;
      end
   end

   initial begin
      int w;
      repeat (3) begin
         @(negedge clk);
         chk("rst_ss_n", SS_n, 1);
         chk("rst_busy", busy, 0);
         chk("rst_rd_data", rd_data, 0);
         chk("rst_done", done, 0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      start = 1'b0;
      send(2'b00, 8'hA5, 8'h00, 1'b1);
      send(2'b11, 8'h00, 8'h3C, 1'b1);
      send(2'b01, 8'h5A, 8'hFF, 1'b1);
      // back-to-back with start held: the second request must chain after exactly G high cycles
      @(negedge clk);
      w = 0;
      while (busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("b2b_idle", busy, 0);
      cmd = 2'b01;
      wdata = 8'hC7;
      start = 1'b1;
      exp_q.push_back('{2'b01, 8'hC7, 8'h00, 1'b0});
      miso_q.push_back(8'h00);
      @(posedge clk);
      #1 cmd = 2'b10;
      wdata = 8'h38;
      exp_q.push_back('{2'b10, 8'h38, 8'h00, 1'b1});
      miso_q.push_back(8'h00);
      @(negedge clk);
      w = 0;
      while (busy && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("b2b_second", busy, 0);
      @(posedge clk);
      #1 start = 1'b0;
      repeat (24) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'b1);
      end
      send(2'b11, 8'h96, 8'hC3, 1'b1);
      // reset during the 5th shift bit of a read-data frame drops it silently
      send(2'b11, 8'h4B, 8'hE1, 1'b0);
      w = 0;
      @(negedge clk);
      while (SS_n && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("mid_sel_seen", SS_n, 0);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ss_n", SS_n, 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_rd_valid", rd_valid, 0);
      chk("mid_rst_rd_data", rd_data, 0);
      chk("mid_rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      send(2'b11, 8'h11, 8'h5E, 1'b1);
      send(2'b10, 8'h22, 8'h00, 1'b1);
      w = 0;
      while (exp_q.size() > 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("queue_drained", exp_q.size(), 0);
      repeat (30) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
